// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width and FSM state encoding.
package uart_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_DONE = 2'b01,
      GAP       = 2'b10
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter signal bundle around the UART TX arbiter.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NREQ = 4
) ();

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]         req;
   logic [UART_DW*NREQ-1:0] req_data;
   logic [NREQ-1:0]         grant;
   logic                    tx_start;
   logic [UART_DW-1:0]      tx_data;
   logic                    tx_done;
   logic                    busy;
   logic                    err;
   logic [IW-1:0]           err_idx;

   // master is the arbiter; slave is the surrounding clients plus transmitter
   modport master (
      input  req, req_data, tx_done,
      output grant, tx_start, tx_data, busy, err, err_idx
   );

   modport slave (
      output req, req_data, tx_done,
      input  grant, tx_start, tx_data, busy, err, err_idx
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate req so ptr is bit 0, take the lowest set bit,
// then rotate the offset back into a requester index.
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            valid,
   output logic [IW-1:0]   idx
);

   logic [NREQ-1:0] rot;
   logic [IW:0]     src;
   logic [IW-1:0]   off;
   logic [IW:0]     sum;

   always_comb begin
      rot = '0;
      src = '0;
      for (int i = 0; i < NREQ; i++) begin
         src = (IW+1)'(i) + {1'b0, ptr};
         if (src >= (IW+1)'(NREQ)) src = src - (IW+1)'(NREQ);
         rot[i] = req[src[IW-1:0]];
      end

      // descending scan so the lowest set bit is the last one written
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IW'(i);
      end

      sum = {1'b0, off} + {1'b0, ptr};
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx   = sum[IW-1:0];
      valid = |req;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers, with a
// frame watchdog and a programmable inter-frame guard gap.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int TIMEOUT    = 20000,
   parameter int GAP_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.master bus
);

   localparam int IW  = $clog2(NREQ);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam arb_state_e AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      cur_idx_q, cur_idx_d;
   logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic               tx_start_q, tx_start_d;
   logic [UART_DW-1:0] tx_data_q, tx_data_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [IW-1:0]      err_idx_q, err_idx_d;

   logic               pick_valid;
   logic [IW-1:0]      pick_idx;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      // NOTE: every _d gets its default before the case, so no path can infer a latch.
      state_d    = state_q;
      ptr_d      = ptr_q;
      cur_idx_d  = cur_idx_q;
      wd_cnt_d   = wd_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      tx_data_d  = tx_data_q;
      err_idx_d  = err_idx_q;
      grant_d    = '0;
      tx_start_d = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               tx_data_d  = bus.req_data[pick_idx*UART_DW +: UART_DW];
               grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
               tx_start_d = 1'b1;
               cur_idx_d  = pick_idx;
               ptr_d      = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
               wd_cnt_d   = '0;
               state_d    = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            // a done arriving on the timeout cycle still counts as a good frame
            if (bus.tx_done) begin
               gap_cnt_d = '0;
               state_d   = AFTER_FRAME;
            end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
               err_d     = 1'b1;
               err_idx_d = cur_idx_q;
               gap_cnt_d = '0;
               state_d   = AFTER_FRAME;
            end
         end

         GAP: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cur_idx_q  <= '0;
         wd_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         grant_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         err_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_idx_q  <= cur_idx_d;
         wd_cnt_q   <= wd_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         grant_q    <= grant_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         err_idx_q  <= err_idx_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
   assign bus.err_idx  = err_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a timestamp-based reference model predicts grants,
// watchdog errors and busy; a negedge monitor compares what the DUT presents.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
   localparam int GAP     = 3;

   typedef struct {
      int          edge_n;
      int          idx;
      logic [7:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .NREQ       (NREQ),
      .TIMEOUT    (TIMEOUT),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   exp_t grant_exp[$];
   exp_t err_exp[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // ---------------- reference model (timestamps, not states) ----------------
   int         arb_edge    = 0;   // first edge at which the arbiter may sample req again
   bit         in_frame    = 0;
   int         start_edge  = 0;
   int         cur         = 0;
   int         m_ptr       = 0;
   logic [7:0] exp_tx_data = 8'h00;
   int         exp_err_idx = 0;
   bit         exp_busy    = 0;
   bit         last_rst    = 0;

   task automatic end_frame();
      in_frame = 0;
      arb_edge = edge_n + GAP + 1;
   endtask

   initial begin
      int winner;
      int cand;
      logic [NREQ-1:0] req_s;
      forever begin
         @(posedge clk);
         edge_n++;
         last_rst = rst;
         if (rst) begin
            m_ptr       = 0;
            in_frame    = 0;
            arb_edge    = edge_n + 1;
            exp_tx_data = 8'h00;
            exp_err_idx = 0;
         end else if (in_frame) begin
            if (bus.tx_done) begin
               end_frame();
            end else if (edge_n - start_edge == TIMEOUT) begin
               err_exp.push_back('{edge_n, cur, 8'h00});
               exp_err_idx = cur;
               end_frame();
            end
         end else if (edge_n >= arb_edge && bus.req != '0) begin
            req_s  = bus.req;
            winner = -1;
            for (int k = 0; k < NREQ; k++) begin
               cand = (m_ptr + k) % NREQ;
               if (winner < 0 && req_s[cand]) winner = cand;
            end
            exp_tx_data = bus.req_data[winner*8 +: 8];
            grant_exp.push_back('{edge_n, winner, exp_tx_data});
            m_ptr      = (winner + 1) % NREQ;
            cur        = winner;
            start_edge = edge_n;
            in_frame   = 1;
         end
         exp_busy = in_frame || (edge_n + 1 < arb_edge);
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t  e;
      string pre;
      forever begin
         @(negedge clk);
         pre = last_rst ? "rst_" : "";
         if (grant_exp.size() > 0 && grant_exp[0].edge_n == edge_n) begin
            e = grant_exp.pop_front();
            check("grant", 32'(bus.grant), 32'(1) << e.idx);
            check("tx_start", 32'(bus.tx_start), 32'(1));
            check("grant_data", 32'(bus.tx_data), 32'(e.data));
         end else begin
            check({pre, "grant_quiet"}, 32'(bus.grant), 32'(0));
            check({pre, "tx_start_quiet"}, 32'(bus.tx_start), 32'(0));
         end
         if (err_exp.size() > 0 && err_exp[0].edge_n == edge_n) begin
            e = err_exp.pop_front();
            check("err", 32'(bus.err), 32'(1));
         end else begin
            check({pre, "err_quiet"}, 32'(bus.err), 32'(0));
         end
         check({pre, "err_idx"}, 32'(bus.err_idx), 32'(exp_err_idx));
         check({pre, "tx_data"}, 32'(bus.tx_data), 32'(exp_tx_data));
         check({pre, "busy"}, 32'(bus.busy), 32'(exp_busy));
      end
   end

   // ---------------- requester clients ----------------
   logic [NREQ-1:0] req_mask = '0;
   int              req_rate = 0;

   initial begin
      bus.req      = '0;
      bus.req_data = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.grant[i]) begin
               bus.req[i] = 1'b0;
            end else if (!bus.req[i] && req_mask[i] && $urandom_range(99) < req_rate) begin
               bus.req[i]            = 1'b1;
               bus.req_data[i*8 +: 8] = 8'($urandom);
            end
         end
      end
   end

   // ---------------- transmitter model ----------------
   // tx_mode: 0 random delay, 1 fixed delay, 2 never answers, 3 answers on the watchdog cycle
   int tx_mode     = 1;
   int fixed_delay = 10;
   bit stray_en    = 0;
   int tx_cnt      = 0;

   initial begin
      int r;
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.tx_done = 1'b0;
         if (bus.tx_start) begin
            r = $urandom_range(99);
            case (tx_mode)
               1:       tx_cnt = fixed_delay;
               2:       tx_cnt = 0;
               3:       tx_cnt = TIMEOUT;
               default: begin
                  if (r < 8)       tx_cnt = 0;
                  else if (r < 16) tx_cnt = TIMEOUT;
                  else if (r < 22) tx_cnt = TIMEOUT - 1;
                  else             tx_cnt = $urandom_range(1, 20);
               end
            endcase
         end
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) bus.tx_done = 1'b1;
         end else if (stray_en && $urandom_range(99) < 3) begin
            bus.tx_done = 1'b1;
         end
      end
   end

   // ---------------- sequence ----------------
   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // single requester, slow transmitter
      req_mask = 4'b0100; req_rate = 100; tx_mode = 1; fixed_delay = 50;
      repeat (70) @(negedge clk);
      req_mask = '0;
      repeat (70) @(negedge clk);

      // all four held, done after 10 cycles: strict rotation
      req_mask = 4'b1111; fixed_delay = 10;
      repeat (150) @(negedge clk);
      req_mask = '0;
      repeat (40) @(negedge clk);

      // sparse pair exercising the pointer wrap
      req_mask = 4'b1000; req_rate = 100;
      repeat (20) @(negedge clk);
      req_mask = 4'b0011;
      repeat (80) @(negedge clk);
      req_mask = '0;
      repeat (40) @(negedge clk);

      // watchdog: silent transmitter, then done exactly on the timeout cycle
      req_mask = 4'b0010; tx_mode = 2;
      repeat (160) @(negedge clk);
      tx_mode = 3; req_mask = 4'b0100;
      repeat (160) @(negedge clk);
      req_mask = '0;
      repeat (80) @(negedge clk);

      // reset mid-frame with a late done still pending
      tx_mode = 1; fixed_delay = 30; req_mask = 4'b1111;
      for (int i = 0; i < 200 && !bus.busy; i++) @(negedge clk);
      check("busy_before_reset", 32'(bus.busy), 32'(1));
      repeat (5) @(negedge clk);
      req_mask = 4'b1000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      req_mask = '0;
      repeat (60) @(negedge clk);

      // randomized traffic with stray dones and occasional resets
      tx_mode = 0; stray_en = 1;
      for (int blk = 0; blk < 60; blk++) begin
         req_mask = 4'($urandom);
         req_rate = $urandom_range(5, 100);
         for (int c = 0; c < 50; c++) begin
            rst = ($urandom_range(499) == 0);
            @(negedge clk);
         end
         rst = 1'b0;
      end

      req_mask = '0; stray_en = 0;
      repeat (TIMEOUT + GAP + 20) @(negedge clk);
      check("grant_queue_drained", 32'(grant_exp.size()), 32'(0));
      check("err_queue_drained", 32'(err_exp.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no end expected finish");
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter among `NREQ` byte producers. It picks one requester at a time, latches that requester's byte and issues a one-cycle start to the transmitter. It then waits for the transmitter's frame-done, with a watchdog and a programmable inter-frame guard gap, before re-arbitrating. The block sits between the client logic and the UART TX/baud-generator pair.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 20000: clock cycles allowed between `tx_start` and `tx_done` before abort.
- `GAP_CYCLES`, 16: idle clock cycles inserted after each frame; 0 means no gap.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester "byte pending" level.
- `req_data`  in  8*NREQ  byte for requester i in bits [8i+7:8i].
- `grant`  out  NREQ  one-hot, one-cycle pulse: requester's byte has been captured.
- `tx_start`  out  1  one-cycle pulse to the transmitter.
- `tx_data`  out  8  registered byte presented to the transmitter; stable from `tx_start` until the next capture.
- `tx_done`  in  1  transmitter frame-complete pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `err_idx`  out  $clog2(NREQ)  index of the requester whose frame timed out; holds until the next `err`.

## Operation
- FSM states:
  - IDLE
  - WAIT_DONE
  - GAP
- IDLE, with `req` != 0:
  - Winner is the first set bit of `req` scanning upward from `ptr`, wrapping modulo NREQ.
  - On that edge: `tx_data` <= winner's byte; `grant` <= onehot(winner); `tx_start` <= 1; `cur_idx` <= winner; `ptr` <= (winner+1) mod NREQ; `wd_cnt` <= 0; next state WAIT_DONE.
- IDLE, with `req` == 0: no change. `ptr` holds.
- WAIT_DONE:
  - `grant` and `tx_start` return to 0 after one cycle.
  - `wd_cnt` increments every cycle.
  - `tx_done`=1: go to GAP, or to IDLE if GAP_CYCLES=0.
  - Else if `wd_cnt` == TIMEOUT-1: `err` <= 1, `err_idx` <= `cur_idx`, then go to GAP (or IDLE).
  - `tx_done` and timeout on the same cycle: done wins and no `err` is raised.
- GAP:
  - `gap_cnt` loads 0 on entry and increments each cycle.
  - Leaves to IDLE when `gap_cnt` == GAP_CYCLES-1.
  - `req` is ignored in GAP.
- `tx_done` seen outside WAIT_DONE is ignored.
- Requester protocol:
  - Holds `req` and `req_data` stable until it sees `grant`.
  - May change them on the cycle after `grant`.
  - The arbiter does not re-sample `req` before the next IDLE.
- Counter widths:
  - `wd_cnt`: $clog2(TIMEOUT+1).
  - `gap_cnt`: $clog2(GAP_CYCLES+1), minimum 1.
  - `ptr`/`cur_idx`: $clog2(NREQ). Wrap is an explicit compare to NREQ-1, never natural overflow.
- Reset (any cycle, including mid-frame):
  - state=IDLE; `ptr`=0; `cur_idx`=0.
  - `grant`=0, `tx_start`=0, `tx_data`=8'h00, `busy`=0, `err`=0, `err_idx`=0.
  - Counters cleared.
  - An in-flight frame is abandoned; a late `tx_done` after reset is ignored.

## Timing
- All outputs are registered.
- Latency from `req` sampled in IDLE to `grant`/`tx_start` high: 1 cycle.
- `busy` rises in the same cycle as `tx_start`. It falls the cycle after leaving WAIT_DONE (GAP_CYCLES=0), or after the last GAP cycle.
- Minimum spacing between consecutive `tx_start` pulses: (cycles to `tx_done`) + GAP_CYCLES + 1.
- `err` is asserted TIMEOUT cycles after `tx_start`.

## Structure
- Shared package `uart_pkg`:
  - State encoding localparams: IDLE=2'b00, WAIT_DONE=2'b01, GAP=2'b10.
  - Byte width constant UART_DW=8.
- Sub-module `rr_pick`, purely combinational:
  - Inputs: `req`, `ptr`.
  - Outputs: `valid`, `idx`.
  - Rotate-then-priority-encode.
  - Instantiated once.

## Test plan
- Single request: NREQ=4, `req`=4'b0100, `req_data[23:16]`=8'hA5 → next cycle `grant`=4'b0100, `tx_start`=1, `tx_data`=8'hA5; `tx_done` 50 cycles later → `busy` low exactly GAP_CYCLES+1 cycles after `tx_done`.
- Fairness: `req`=4'b1111 held, each `tx_done` returned after 10 cycles → grants in order 0,1,2,3,0; no index repeats before all four are served.
- Wrap with sparse requests: `ptr`=3, `req`=4'b0011 → grant requester 0, then 1; `ptr` becomes 1, then 2.
- Watchdog: TIMEOUT=100, no `tx_done` → `err` pulses 100 cycles after `tx_start` with `err_idx`=granted index; `tx_done` on that same cycle instead → no `err`.
- Reset mid-frame: assert `rst` in WAIT_DONE → all outputs at reset values next cycle; stray `tx_done` afterwards causes no state change; `req`=4'b1000 → grant 3 (`ptr` was reset to 0).
- GAP_CYCLES=0 back-to-back: `req`=4'b0001 held, `tx_done` after 5 cycles → next `tx_start` exactly 1 cycle after `tx_done`; `req` during GAP (nonzero GAP) is not granted early.
